// File: rtl/cache_op_ctrl.sv
// cache_op_ctrl - top-level command controller for the Redis-style cache.
//
// Accepts one host command (NOOP/READ/CREATE/UPDATE/DELETE) per transaction,
// maps it onto a top state (GET/PUT/SET/DEL), issues a single sub-command to
// the storage back end and supervises it with a timeout and a bounded retry
// count, then returns one response (status, data, echoed opcode).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           host command handshake
//   cmd_op/cmd_key/cmd_value      host command fields
//   sub_req_valid/sub_req_ready   back-end request handshake
//   sub_req_op/key/value          latched request fields
//   sub_done/sub_error/sub_rdata  back-end completion pulses and read data
//   sub_abort                     1-cycle pulse when an attempt times out
//   resp_valid/resp_ready         host response handshake
//   resp_status/resp_op/resp_data response fields
//   state_o                       top state: IDLE 0, GET 1, SET 2, PUT 3, DEL 4, ERR 5
//
// Optional feature: define CACHE_OP_CTRL_STATS_EN to add the saturating
// 16-bit counters stat_ok_cnt, stat_err_cnt and stat_retry_cnt.
module cache_op_ctrl #(
    parameter int KEY_W          = 16,
    parameter int VAL_W          = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    input  logic [VAL_W-1:0] cmd_value,
    output logic             sub_req_valid,
    input  logic             sub_req_ready,
    output logic [2:0]       sub_req_op,
    output logic [KEY_W-1:0] sub_req_key,
    output logic [VAL_W-1:0] sub_req_value,
    input  logic             sub_done,
    input  logic             sub_error,
    input  logic [VAL_W-1:0] sub_rdata,
    output logic             sub_abort,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_status,
    output logic [2:0]       resp_op,
    output logic [VAL_W-1:0] resp_data,
    output logic [2:0]       state_o
`ifdef CACHE_OP_CTRL_STATS_EN
    ,
    output logic [15:0]      stat_ok_cnt,
    output logic [15:0]      stat_err_cnt,
    output logic [15:0]      stat_retry_cnt
`endif
);

    localparam logic [2:0] OP_NOOP   = 3'd0;
    localparam logic [2:0] OP_READ   = 3'd1;
    localparam logic [2:0] OP_CREATE = 3'd2;
    localparam logic [2:0] OP_UPDATE = 3'd3;
    localparam logic [2:0] OP_DELETE = 3'd4;

    localparam logic [1:0] RS_OK      = 2'd0;
    localparam logic [1:0] RS_SUB_ERR = 2'd1;
    localparam logic [1:0] RS_TIMEOUT = 2'd2;
    localparam logic [1:0] RS_ILLEGAL = 2'd3;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_GET = 3'd1, ST_SET = 3'd2,
        ST_PUT  = 3'd3, ST_DEL = 3'd4, ST_ERR = 3'd5
    } top_t;

    // Phase within the top state. NOOP responds from PH_RESP while the top
    // state stays IDLE; cmd_ready follows the phase, not the top state.
    typedef enum logic [2:0] {
        PH_IDLE, PH_ISSUE, PH_WAIT, PH_ABORT, PH_RESP
    } phase_t;

    top_t            top;
    phase_t          phase;
    logic [TW-1:0]   tmo_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            retry_ev;

    assign state_o  = top;
    // Error wins over a simultaneous done; retry only while budget remains.
    assign retry_ev = (phase == PH_WAIT) && sub_error && (retry_cnt < MAX_R);

    always_ff @(posedge clk) begin
        if (rst) begin
            top           <= ST_IDLE;
            phase         <= PH_IDLE;
            tmo_cnt       <= '0;
            retry_cnt     <= '0;
            cmd_ready     <= 1'b1;
            sub_req_valid <= 1'b0;
            sub_req_op    <= '0;
            sub_req_key   <= '0;
            sub_req_value <= '0;
            sub_abort     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_status   <= '0;
            resp_op       <= '0;
            resp_data     <= '0;
        end else begin
            sub_abort <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready     <= 1'b0;
                        sub_req_op    <= cmd_op;
                        sub_req_key   <= cmd_key;
                        sub_req_value <= cmd_value;
                        tmo_cnt       <= '0;
                        retry_cnt     <= '0;
                        resp_op       <= cmd_op;
                        resp_data     <= '0;
                        case (cmd_op)
                            OP_NOOP: begin
                                phase       <= PH_RESP;
                                resp_valid  <= 1'b1;
                                resp_status <= RS_OK;
                            end
                            OP_READ, OP_CREATE, OP_UPDATE, OP_DELETE: begin
                                phase         <= PH_ISSUE;
                                sub_req_valid <= 1'b1;
                                case (cmd_op)
                                    OP_READ:   top <= ST_GET;
                                    OP_CREATE: top <= ST_PUT;
                                    OP_UPDATE: top <= ST_SET;
                                    default:   top <= ST_DEL;
                                endcase
                            end
                            default: begin
                                top         <= ST_ERR;
                                phase       <= PH_RESP;
                                resp_valid  <= 1'b1;
                                resp_status <= RS_ILLEGAL;
                            end
                        endcase
                    end
                end
                PH_ISSUE: begin
                    if (sub_req_ready) begin
                        sub_req_valid <= 1'b0;
                        phase         <= PH_WAIT;
                        tmo_cnt       <= '0;
                    end
                end
                PH_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // Done/error take priority over the final timeout cycle.
                    if (retry_ev) begin
                        retry_cnt     <= retry_cnt + 1'b1;
                        phase         <= PH_ISSUE;
                        sub_req_valid <= 1'b1;
                    end else if (sub_error) begin
                        top         <= ST_ERR;
                        phase       <= PH_RESP;
                        resp_valid  <= 1'b1;
                        resp_status <= RS_SUB_ERR;
                    end else if (sub_done) begin
                        phase       <= PH_RESP;
                        resp_valid  <= 1'b1;
                        resp_status <= RS_OK;
                        resp_data   <= (sub_req_op == OP_READ) ? sub_rdata : '0;
                    end else if (tmo_cnt == TO_LAST) begin
                        sub_abort <= 1'b1;
                        phase     <= PH_ABORT;
                    end
                end
                PH_ABORT: begin
                    top         <= ST_ERR;
                    phase       <= PH_RESP;
                    resp_valid  <= 1'b1;
                    resp_status <= RS_TIMEOUT;
                end
                PH_RESP: begin
                    if (resp_ready) begin
                        top         <= ST_IDLE;
                        phase       <= PH_IDLE;
                        cmd_ready   <= 1'b1;
                        resp_valid  <= 1'b0;
                        resp_status <= '0;
                        resp_data   <= '0;
                        tmo_cnt     <= '0;
                        retry_cnt   <= '0;
                    end
                end
                default: begin
                    top       <= ST_IDLE;
                    phase     <= PH_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CACHE_OP_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ok_cnt    <= '0;
            stat_err_cnt   <= '0;
            stat_retry_cnt <= '0;
        end else begin
            if (resp_valid && resp_ready) begin
                if (resp_status == RS_OK) stat_ok_cnt  <= sat_inc(stat_ok_cnt);
                else                      stat_err_cnt <= sat_inc(stat_err_cnt);
            end
            if (retry_ev) stat_retry_cnt <= sat_inc(stat_retry_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_cache_op_ctrl.sv
// Directed bench for cache_op_ctrl. Instance u0 uses TIMEOUT_CYCLES=8 and
// MAX_RETRIES=2; instance u1 uses MAX_RETRIES=0 and is only given commands
// in the same-cycle done/error collision step.
module tb_cache_op_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, b_cmd_valid;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_key;
    logic [31:0] cmd_value;
    logic        sub_req_ready, sub_done, sub_error;
    logic [31:0] sub_rdata;
    logic        resp_ready, b_resp_ready;

    logic        cmd_ready, sub_req_valid, sub_abort, resp_valid;
    logic [2:0]  sub_req_op, resp_op, state_o;
    logic [15:0] sub_req_key;
    logic [31:0] sub_req_value, resp_data;
    logic [1:0]  resp_status;

    logic        b_cmd_ready, b_sub_req_valid, b_sub_abort, b_resp_valid;
    logic [2:0]  b_sub_req_op, b_resp_op, b_state;
    logic [15:0] b_sub_req_key;
    logic [31:0] b_sub_req_value, b_resp_data;
    logic [1:0]  b_resp_status;
`ifdef CACHE_OP_CTRL_STATS_EN
    logic [15:0] ok_cnt, err_cnt, rty_cnt, b_ok_cnt, b_err_cnt, b_rty_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_op_ctrl #(.KEY_W(16), .VAL_W(32), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_value(cmd_value),
        .sub_req_valid(sub_req_valid), .sub_req_ready(sub_req_ready),
        .sub_req_op(sub_req_op), .sub_req_key(sub_req_key), .sub_req_value(sub_req_value),
        .sub_done(sub_done), .sub_error(sub_error), .sub_rdata(sub_rdata),
        .sub_abort(sub_abort), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_op(resp_op), .resp_data(resp_data),
        .state_o(state_o)
`ifdef CACHE_OP_CTRL_STATS_EN
        , .stat_ok_cnt(ok_cnt), .stat_err_cnt(err_cnt), .stat_retry_cnt(rty_cnt)
`endif
    );

    cache_op_ctrl #(.KEY_W(16), .VAL_W(32), .TIMEOUT_CYCLES(8), .MAX_RETRIES(0)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_value(cmd_value),
        .sub_req_valid(b_sub_req_valid), .sub_req_ready(sub_req_ready),
        .sub_req_op(b_sub_req_op), .sub_req_key(b_sub_req_key), .sub_req_value(b_sub_req_value),
        .sub_done(sub_done), .sub_error(sub_error), .sub_rdata(sub_rdata),
        .sub_abort(b_sub_abort), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_status(b_resp_status), .resp_op(b_resp_op), .resp_data(b_resp_data),
        .state_o(b_state)
`ifdef CACHE_OP_CTRL_STATS_EN
        , .stat_ok_cnt(b_ok_cnt), .stat_err_cnt(b_err_cnt), .stat_retry_cnt(b_rty_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response handshake on u0, then back in IDLE.
    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] key, input logic [31:0] val);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_value = val;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int wc;
        int aborts;
        logic stable;

        rst = 1'b1; cmd_valid = 1'b0; b_cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0;
        cmd_value = '0; sub_req_ready = 1'b0; sub_done = 1'b0; sub_error = 1'b0;
        sub_rdata = '0; resp_ready = 1'b0; b_resp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_sub_req_valid", {31'd0, sub_req_valid}, 32'd0);

        // READ, ready back end, done on first WAIT cycle
        sub_req_ready = 1'b1;
        issue(3'd1, 16'h00A5, 32'h0);
        chk("rd_state_get", {29'd0, state_o}, 32'd1);
        chk("rd_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("rd_req_valid", {31'd0, sub_req_valid}, 32'd1);
        chk("rd_req_key", {16'd0, sub_req_key}, 32'h00A5);
        chk("rd_req_op", {29'd0, sub_req_op}, 32'd1);
        tick();
        chk("rd_wait_no_resp", {31'd0, resp_valid}, 32'd0);
        sub_done = 1'b1; sub_rdata = 32'hDEADBEEF;
        tick();
        sub_done = 1'b0; sub_rdata = 32'h0;
        chk("rd_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("rd_status", {30'd0, resp_status}, 32'd0);
        chk("rd_data", resp_data, 32'hDEADBEEF);
        chk("rd_resp_op", {29'd0, resp_op}, 32'd1);
        finish_resp();
        chk("rd_back_idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rd_back_idle_state", {29'd0, state_o}, 32'd0);

        // UPDATE: two errors then done
        issue(3'd3, 16'h0033, 32'h12345678);
        chk("up_state_set", {29'd0, state_o}, 32'd2);
        chk("up_req_value", sub_req_value, 32'h12345678);
        hs = 0;
        for (int a = 0; a < 3; a++) begin
            if (sub_req_valid === 1'b1) hs++;
            tick();
            if (a < 2) sub_error = 1'b1;
            else begin sub_done = 1'b1; sub_rdata = 32'hFFFF0000; end
            tick();
            sub_error = 1'b0; sub_done = 1'b0; sub_rdata = 32'h0;
        end
        chk("up_handshakes", hs, 32'd3);
        chk("up_status", {30'd0, resp_status}, 32'd0);
        chk("up_data", resp_data, 32'd0);
        chk("up_resp_op", {29'd0, resp_op}, 32'd3);
        finish_resp();

        // UPDATE: three errors exhaust the retries
        issue(3'd3, 16'h0034, 32'h1);
        hs = 0;
        for (int a = 0; a < 3; a++) begin
            if (sub_req_valid === 1'b1) hs++;
            tick();
            sub_error = 1'b1;
            tick();
            sub_error = 1'b0;
        end
        chk("up3_handshakes", hs, 32'd3);
        chk("up3_no_reissue", {31'd0, sub_req_valid}, 32'd0);
        chk("up3_status", {30'd0, resp_status}, 32'd1);
        chk("up3_state_err", {29'd0, state_o}, 32'd5);
        finish_resp();

        // DELETE, back end silent: timeout after 8 WAIT cycles
        issue(3'd4, 16'h0077, 32'h0);
        tick();
        wc = 0;
        while (sub_abort !== 1'b1 && wc < 20) begin
            wc++;
            tick();
        end
        chk("del_wait_cycles", wc, 32'd8);
        tick();
        chk("del_abort_single", {31'd0, sub_abort}, 32'd0);
        chk("del_state_err", {29'd0, state_o}, 32'd5);
        chk("del_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("del_status", {30'd0, resp_status}, 32'd2);
        chk("del_resp_op", {29'd0, resp_op}, 32'd4);
        finish_resp();

        // Illegal opcode
        issue(3'd6, 16'h0001, 32'h0);
        chk("ill_no_req", {31'd0, sub_req_valid}, 32'd0);
        chk("ill_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("ill_status", {30'd0, resp_status}, 32'd3);
        chk("ill_resp_op", {29'd0, resp_op}, 32'd6);
        finish_resp();

        // NOOP
        issue(3'd0, 16'h0002, 32'h5);
        chk("noop_no_req", {31'd0, sub_req_valid}, 32'd0);
        chk("noop_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("noop_status", {30'd0, resp_status}, 32'd0);
        chk("noop_data", resp_data, 32'd0);
        finish_resp();

        // CREATE with resp_ready held low for 5 cycles
        issue(3'd2, 16'h0100, 32'hCAFE0001);
        chk("cr_state_put", {29'd0, state_o}, 32'd3);
        tick();
        sub_done = 1'b1; sub_rdata = 32'hAAAA5555;
        tick();
        sub_done = 1'b0; sub_rdata = 32'h0;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stable &= (resp_valid === 1'b1) && (resp_status === 2'd0) && (resp_data === 32'd0)
                      && (resp_op === 3'd2) && (cmd_ready === 1'b0) && (state_o === 3'd3);
            tick();
        end
        chk("cr_hold_stable", {31'd0, stable}, 32'd1);
        finish_resp();

        // READ interrupted by reset in WAIT
        issue(3'd1, 16'h0200, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mr_state", {29'd0, state_o}, 32'd0);
        chk("mr_req_key", {16'd0, sub_req_key}, 32'd0);
        aborts = 0; stable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (sub_abort === 1'b1) aborts++;
            stable &= (resp_valid === 1'b0) && (sub_req_valid === 1'b0);
            tick();
        end
        chk("mr_no_abort", aborts, 32'd0);
        chk("mr_no_resp", {31'd0, stable}, 32'd1);

        // u1 (no retries): done and error in the same cycle
        b_cmd_valid = 1'b1; cmd_op = 3'd1; cmd_key = 16'h0300;
        tick();
        b_cmd_valid = 1'b0;
        tick();
        sub_done = 1'b1; sub_error = 1'b1; sub_rdata = 32'h11111111;
        tick();
        sub_done = 1'b0; sub_error = 1'b0; sub_rdata = 32'h0;
        chk("col_resp_valid", {31'd0, b_resp_valid}, 32'd1);
        chk("col_status", {30'd0, b_resp_status}, 32'd1);
        chk("col_state_err", {29'd0, b_state}, 32'd5);
        chk("col_data", b_resp_data, 32'd0);
        b_resp_ready = 1'b1;
        tick();
        b_resp_ready = 1'b0;
        chk("col_back_idle", {31'd0, b_cmd_ready}, 32'd1);

        // u0: done arrives in the final timeout cycle
        issue(3'd1, 16'h0400, 32'h0);
        tick();
        aborts = 0;
        for (int i = 0; i < 7; i++) begin
            if (sub_abort === 1'b1) aborts++;
            tick();
        end
        sub_done = 1'b1; sub_rdata = 32'h0BADF00D;
        tick();
        sub_done = 1'b0; sub_rdata = 32'h0;
        if (sub_abort === 1'b1) aborts++;
        chk("lt_no_abort", aborts, 32'd0);
        chk("lt_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lt_status", {30'd0, resp_status}, 32'd0);
        chk("lt_data", resp_data, 32'h0BADF00D);
        tick();
        chk("lt_abort_after", {31'd0, sub_abort}, 32'd0);
        finish_resp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_op_ctrl.md
Name: cache_op_ctrl

Overview:
- Parametrised top-level command controller for the Redis-style cache.
- Accepts one host command per transaction (NOOP/READ/CREATE/UPDATE/DELETE) over a valid/ready handshake and maps it to a top state: GET, PUT, SET or DEL.
- Issues a single sub-command to the storage back end and supervises it with a timeout and a bounded retry count.
- Returns one response carrying status, data and the echoed opcode.

Parameters:
- KEY_W, 16, key width in bits.
- VAL_W, 32, value width in bits.
- TIMEOUT_CYCLES, 64, maximum number of WAIT cycles per sub-command attempt (≥2).
- MAX_RETRIES, 2, re-issues allowed after sub_error; 0 disables retry.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  opcode: 0 NOOP, 1 READ, 2 CREATE, 3 UPDATE, 4 DELETE, 5-7 illegal.
- cmd_key  in  KEY_W  command key.
- cmd_value  in  VAL_W  write value (CREATE/UPDATE).
- sub_req_valid  out  1  back-end request valid.
- sub_req_ready  in  1  back end accepts request.
- sub_req_op  out  3  opcode forwarded to the back end.
- sub_req_key  out  KEY_W  latched key.
- sub_req_value  out  VAL_W  latched value.
- sub_done  in  1  back end completed successfully (1-cycle pulse).
- sub_error  in  1  back end failed (1-cycle pulse).
- sub_rdata  in  VAL_W  read data, valid with sub_done.
- sub_abort  out  1  1-cycle pulse on timeout.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts response.
- resp_status  out  2  0 OK, 1 SUB_ERR, 2 TIMEOUT, 3 ILLEGAL_OP.
- resp_op  out  3  echoed opcode.
- resp_data  out  VAL_W  read data; 0 unless READ with status OK.
- state_o  out  3  current top state: IDLE 0, GET 1, SET 2, PUT 3, DEL 4, ERR 5.

Behaviour:
- Reset: state IDLE, all outputs 0 except cmd_ready=1, and retry and timeout counters cleared.
- Reset asserted mid-operation drops the transaction. No sub_abort and no response are issued.
- cmd_ready=1 only in IDLE.
- On accept (cmd_valid & cmd_ready): latch op, key and value, then go to READ→GET, UPDATE→SET, CREATE→PUT or DELETE→DEL. The phase is ISSUE.
- NOOP goes to RESP next cycle with status OK and data 0. The back end is not touched.
- Opcodes 5-7 go to ERR with ILLEGAL_OP, and the response is presented next cycle.
- Each op state has phases ISSUE → WAIT → RESP:
  - ISSUE: sub_req_valid held high with stable fields until sub_req_ready; the phase then moves to WAIT with the timeout counter at 0.
  - WAIT: the counter increments each cycle.
  - sub_done → RESP with OK; sub_rdata is captured if the op is READ.
  - sub_error with retries < MAX_RETRIES → increment retries and return to ISSUE.
  - sub_error with retries exhausted → ERR with SUB_ERR.
  - Counter reaching TIMEOUT_CYCLES-1 with no done or error → pulse sub_abort for 1 cycle, then ERR with TIMEOUT. No retry is made on timeout.
- Same-cycle collisions:
  - sub_done and sub_error together: error wins.
  - Done or error in the final timeout cycle: done or error wins over the timeout.
- sub_done/sub_error outside WAIT are ignored.
- RESP and ERR hold resp_valid and all response fields stable until resp_ready. They then return to IDLE and clear the counters.
- cmd_ready is 1 in the cycle after the handshake. Back-to-back commands are accepted every 3+ cycles.
- Minimum latency with an immediately ready back end and sub_done on the first WAIT cycle: accept → resp_valid in 3 cycles.

Optional Feature:
- Macro: CACHE_OP_CTRL_STATS_EN.
- When defined:
  - Adds outputs stat_ok_cnt, stat_err_cnt and stat_retry_cnt, each 16 bits.
  - They increment on each OK response handshake, each non-OK response handshake and each retry respectively.
  - They saturate at 0xFFFF and are cleared by rst.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- READ key 0x00A5, back end ready immediately, sub_done + sub_rdata=0xDEADBEEF on first WAIT cycle → resp_valid 3 cycles after accept, status 0, data 0xDEADBEEF, resp_op 1, state_o passes 1.
- UPDATE with sub_error twice then sub_done (MAX_RETRIES=2) → three sub_req_valid handshakes, status 0, data 0; with three errors → status 1 after the third attempt.
- DELETE, back end never responds, TIMEOUT_CYCLES=8 → single sub_abort pulse after 8 WAIT cycles, state_o 5, status 2.
- cmd_op=6 → no sub_req_valid, response next cycle with status 3, resp_op 6.
- CREATE with resp_ready low for 5 cycles → response fields stable, cmd_ready 0 throughout; rst asserted in WAIT of a following READ → all outputs at reset values next cycle, no response.
- sub_done and sub_error same cycle with MAX_RETRIES=0 → status 1; sub_done in the last timeout cycle → status 0, no sub_abort.
